// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: result, controls, store data,
// status flags (C/N/V/Z) and a signed-overflow trap with count.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStall,
    input  logic              iFlush,
    input  logic              iValid,
    input  logic [3:0]        iSA,
    input  logic [DATA_W-1:0] iResult,
    input  logic              iCarry,
    input  logic              iNegative,
    input  logic              iOverflow,
    input  logic [RA_W-1:0]   iRd,
    input  logic              iRegWe,
    input  logic              iMemRe,
    input  logic              iMemWe,
    input  logic [DATA_W-1:0] iStoreData,
    input  logic              iFlagWe,
    input  logic              iTrapEn,
    output logic              oValid,
    output logic [DATA_W-1:0] oResult,
    output logic [RA_W-1:0]   oRd,
    output logic              oRegWe,
    output logic              oMemRe,
    output logic              oMemWe,
    output logic [DATA_W-1:0] oStoreData,
    output logic              oC,
    output logic              oN,
    output logic              oV,
    output logic              oZ,
    output logic              oTrap,
    output logic [CNT_W-1:0]  oTrapCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic capture;
    logic take;
    logic trap_hit;
    logic flag_upd;
    logic sa_unused;

    // Only the signed bit steers this stage; the rest belong to the adder.
    assign sa_unused = ^{iSA[3:2], iSA[0]};

    assign capture  = !iFlush && !iStall;
    assign take     = capture && iValid;
    assign trap_hit = take && iSA[1] && iOverflow && iTrapEn;
    assign flag_upd = take && iFlagWe;

    // Datapath loads on capture and holds on stall or flush.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oResult    <= '0;
            oRd        <= '0;
            oStoreData <= '0;
        end else if (capture) begin
            oResult    <= iResult;
            oRd        <= iRd;
            oStoreData <= iStoreData;
        end
    end

    // Controls: flush inserts a bubble, a trapping instruction is squashed.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oValid <= 1'b0;
            oRegWe <= 1'b0;
            oMemRe <= 1'b0;
            oMemWe <= 1'b0;
            oTrap  <= 1'b0;
        end else if (iFlush) begin
            oValid <= 1'b0;
            oRegWe <= 1'b0;
            oMemRe <= 1'b0;
            oMemWe <= 1'b0;
            oTrap  <= 1'b0;
        end else if (iStall) begin
            oTrap  <= 1'b0;
        end else begin
            oValid <= iValid;
            oRegWe <= take && iRegWe && !trap_hit;
            oMemRe <= take && iMemRe && !trap_hit;
            oMemWe <= take && iMemWe && !trap_hit;
            oTrap  <= trap_hit;
        end
    end

    // Flags: Z always; C in unsigned mode, N/V in signed mode.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oC <= 1'b0;
            oN <= 1'b0;
            oV <= 1'b0;
            oZ <= 1'b0;
        end else if (flag_upd) begin
            oZ <= (iResult == '0);
            if (iSA[1]) begin
                oN <= iNegative;
                oV <= iOverflow;
            end else begin
                oC <= iCarry;
            end
        end
    end

    // Saturating trap counter; never wraps.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oTrapCnt <= '0;
        end else if (trap_hit && (oTrapCnt != CNT_MAX)) begin
            oTrapCnt <= oTrapCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed vectors push expected
// outputs; a monitor pops and compares after every rising edge.
module tb_ex_mem_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regwe;
        logic        memre;
        logic        memwe;
        logic [31:0] store;
        logic        c;
        logic        n;
        logic        v;
        logic        z;
        logic        trap;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } item_t;

    logic        iClk;
    logic        iRst_n;
    logic        iStall;
    logic        iFlush;
    logic        iValid;
    logic [3:0]  iSA;
    logic [31:0] iResult;
    logic        iCarry;
    logic        iNegative;
    logic        iOverflow;
    logic [4:0]  iRd;
    logic        iRegWe;
    logic        iMemRe;
    logic        iMemWe;
    logic [31:0] iStoreData;
    logic        iFlagWe;
    logic        iTrapEn;
    logic        oValid;
    logic [31:0] oResult;
    logic [4:0]  oRd;
    logic        oRegWe;
    logic        oMemRe;
    logic        oMemWe;
    logic [31:0] oStoreData;
    logic        oC;
    logic        oN;
    logic        oV;
    logic        oZ;
    logic        oTrap;
    logic [7:0]  oTrapCnt;

    int checks;
    int failures;
    item_t sbq[$];

    ex_mem_reg #(
        .DATA_W(32),
        .RA_W  (5),
        .CNT_W (8)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStall    (iStall),
        .iFlush    (iFlush),
        .iValid    (iValid),
        .iSA       (iSA),
        .iResult   (iResult),
        .iCarry    (iCarry),
        .iNegative (iNegative),
        .iOverflow (iOverflow),
        .iRd       (iRd),
        .iRegWe    (iRegWe),
        .iMemRe    (iMemRe),
        .iMemWe    (iMemWe),
        .iStoreData(iStoreData),
        .iFlagWe   (iFlagWe),
        .iTrapEn   (iTrapEn),
        .oValid    (oValid),
        .oResult   (oResult),
        .oRd       (oRd),
        .oRegWe    (oRegWe),
        .oMemRe    (oMemRe),
        .oMemWe    (oMemWe),
        .oStoreData(oStoreData),
        .oC        (oC),
        .oN        (oN),
        .oV        (oV),
        .oZ        (oZ),
        .oTrap     (oTrap),
        .oTrapCnt  (oTrapCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic exp_t act();
        return {oValid, oResult, oRd, oRegWe, oMemRe, oMemWe,
                oStoreData, oC, oN, oV, oZ, oTrap, oTrapCnt};
    endfunction

    function automatic exp_t mk(
        input logic        v,
        input logic [31:0] r,
        input logic [4:0]  rd,
        input logic        rw,
        input logic        mr,
        input logic        mw,
        input logic [31:0] sd,
        input logic        c,
        input logic        n,
        input logic        vv,
        input logic        z,
        input logic        t,
        input logic [7:0]  cnt
    );
        return {v, r, rd, rw, mr, mw, sd, c, n, vv, z, t, cnt};
    endfunction

    task automatic chk(input string nm, input exp_t got,
                       input exp_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic drv(
        input logic        v,
        input logic [3:0]  sa,
        input logic [31:0] r,
        input logic        c,
        input logic        n,
        input logic        ov,
        input logic [4:0]  rd,
        input logic        rw,
        input logic        mr,
        input logic        mw,
        input logic [31:0] sd,
        input logic        fw,
        input logic        te
    );
        iValid     = v;
        iSA        = sa;
        iResult    = r;
        iCarry     = c;
        iNegative  = n;
        iOverflow  = ov;
        iRd        = rd;
        iRegWe     = rw;
        iMemRe     = mr;
        iMemWe     = mw;
        iStoreData = sd;
        iFlagWe    = fw;
        iTrapEn    = te;
    endtask

    task automatic cyc(input string nm, input exp_t e);
        item_t it;
        it.name = nm;
        it.e    = e;
        sbq.push_back(it);
        @(negedge iClk);
    endtask

    // Monitor: one expected item per rising edge while stimulus is queued.
    always @(posedge iClk) begin
        item_t it;
        #1;
        if (sbq.size() > 0) begin
            it = sbq.pop_front();
            chk(it.name, act(), it.e);
        end
    end

    localparam logic [31:0] OVF_R = 32'h8000_0000;

    initial begin
        checks   = 0;
        failures = 0;
        iRst_n   = 1'b0;
        iStall   = 1'b1;
        iFlush   = 1'b1;
        drv(1, 4'hF, 32'hFFFF_FFFF, 1, 1, 1, 5'h1F,
            1, 1, 1, 32'hFFFF_FFFF, 1, 1);
        repeat (3) @(negedge iClk);
        chk("reset_hold", act(), '0);

        iStall = 1'b0;
        iFlush = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        iRst_n = 1'b1;
        cyc("post_reset", mk(0, 0, 0, 0, 0, 0, 0,
                             0, 0, 0, 0, 0, 0));

        drv(1, 4'b0010, OVF_R, 0, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0);
        cyc("sgn_ovf_notrap", mk(1, OVF_R, 5'd3, 1, 0, 0, 0,
                                 0, 1, 1, 0, 0, 0));

        drv(1, 4'b0000, 0, 1, 1, 1, 5'd5, 1, 0, 0, 0, 1, 0);
        cyc("uadd", mk(1, 0, 5'd5, 1, 0, 0, 0,
                       1, 1, 1, 1, 0, 0));

        drv(1, 4'b0011, 32'hFFFF_FFFF, 0, 1, 0, 5'd7,
            1, 0, 0, 0, 1, 0);
        cyc("ssub", mk(1, 32'hFFFF_FFFF, 5'd7, 1, 0, 0, 0,
                       1, 1, 0, 0, 0, 0));

        drv(0, 4'b0000, 32'h1234, 1, 1, 1, 5'd9,
            1, 1, 1, 32'hAAAA, 1, 1);
        cyc("bubble", mk(0, 32'h1234, 5'd9, 0, 0, 0, 32'hAAAA,
                         1, 1, 0, 0, 0, 0));

        drv(1, 4'b0010, OVF_R, 0, 1, 1, 5'd1,
            1, 0, 1, 32'h55, 1, 1);
        for (int i = 1; i <= 100; i++)
            cyc("trap_pre", mk(1, OVF_R, 5'd1, 0, 0, 0, 32'h55,
                               1, 1, 1, 0, 1, 8'(i)));

        iFlush = 1'b1;
        cyc("flush_trap", mk(0, OVF_R, 5'd1, 0, 0, 0, 32'h55,
                             1, 1, 1, 0, 0, 8'd100));
        iFlush = 1'b0;

        for (int i = 101; i <= 254; i++)
            cyc("trap_pre", mk(1, OVF_R, 5'd1, 0, 0, 0, 32'h55,
                               1, 1, 1, 0, 1, 8'(i)));

        repeat (3)
            cyc("trap_sat", mk(1, OVF_R, 5'd1, 0, 0, 0, 32'h55,
                               1, 1, 1, 0, 1, 8'd255));

        iStall = 1'b1;
        drv(1, 4'b0000, 0, 0, 0, 0, 5'd10, 1, 0, 0, 32'h77, 1, 0);
        repeat (3)
            cyc("stall", mk(1, OVF_R, 5'd1, 0, 0, 0, 32'h55,
                            1, 1, 1, 0, 0, 8'd255));

        iStall = 1'b0;
        cyc("stall_rel", mk(1, 0, 5'd10, 1, 0, 0, 32'h77,
                            0, 1, 1, 1, 0, 8'd255));

        drv(1, 4'b0000, 32'h100, 0, 0, 0, 5'd0,
            0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        cyc("store", mk(1, 32'h100, 5'd0, 0, 0, 1, 32'hDEAD_BEEF,
                        0, 1, 1, 1, 0, 8'd255));

        iStall = 1'b1;
        iFlush = 1'b1;
        drv(1, 4'b0010, 32'h9, 0, 1, 1, 5'd2,
            1, 0, 1, 32'h1, 1, 1);
        cyc("stall_flush", mk(0, 32'h100, 5'd0, 0, 0, 0,
                              32'hDEAD_BEEF, 0, 1, 1, 1, 0, 8'd255));

        iFlush = 1'b0;
        #2;
        iRst_n = 1'b0;
        #1;
        chk("async_rst", act(), '0);

        @(negedge iClk);
        iRst_n = 1'b1;
        iStall = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("after_rst", mk(0, 0, 0, 0, 0, 0, 0,
                            0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 10 && sbq.size() > 0; k++)
            @(negedge iClk);
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
